// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and widths for the SAR conversion sequencer
package sar_pkg;

  // Default conversion resolution in bits
  localparam int SAR_NBIT_DEF = 10;

  // Sample-phase and comparator-timeout counter widths (both ranges are 1..255)
  localparam int SAMPLE_CNT_W = 8;
  localparam int TMO_CNT_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAMPLE   = 3'd1,
    ST_COMPARE  = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DECIDE   = 3'd4,
    ST_DONE     = 3'd5
  } sar_state_e;

endpackage

// File: rtl/sar_rdy_sync.sv
// rtl/sar_rdy_sync.sv - 2-FF synchronizer with rising-edge pulse for analog ready signals
module sar_rdy_sync (
  input  logic CLK,
  input  logic RSTN,
  input  logic D,
  output logic P
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Two synchronizing stages, then one delay stage so a level becomes a single pulse
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= D;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign P = sync_q & ~dly_q;

endmodule

// File: rtl/sar_conv_ctrl.sv
// rtl/sar_conv_ctrl.sv - SAR conversion sequencer; optional comparator timeout via SAR_COMP_TIMEOUT_EN
module sar_conv_ctrl
  import sar_pkg::*;
#(
  parameter int NBIT        = SAR_NBIT_DEF,
  parameter int SAMPLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START,
  input  logic            COMP_RDY,
  input  logic            COMP_OUT,
  output logic            CKS,
  output logic            CLKC,
  output logic [NBIT-1:0] DAC,
  output logic            BUSY,
  output logic [NBIT-1:0] DOUT,
  output logic            VALID,
  output logic            ERR
);

  localparam int IDX_W = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_LAST = SAMPLE_CNT_W'(SAMPLE_CYC - 1);

  if (SAMPLE_CYC < 1 || SAMPLE_CYC > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("sar_conv_ctrl: SAMPLE_CYC and TIMEOUT_CYC must lie in 1..255");
  end

  sar_state_e state_q, state_d;
  logic [SAMPLE_CNT_W-1:0] scnt_q, scnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NBIT-1:0]         sar_q, sar_d;
  logic [NBIT-1:0]         dout_q, dout_d;
  logic comp_q, comp_d;
  logic cks_q, cks_d;
  logic clkc_q, clkc_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic rdy_p;
  logic start_ok;
  logic tmo_hit;

  sar_rdy_sync u_rdy_sync (
    .CLK  (CLK),
    .RSTN (RSTN),
    .D    (COMP_RDY),
    .P    (rdy_p)
  );

  // BUSY stays high through the VALID/ERR cycle, so IDLE must also see it low to accept START
  assign start_ok = START & ~busy_q;

`ifdef SAR_COMP_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYC - 1);
  logic [TMO_CNT_W-1:0] tcnt_q, tcnt_d;
  assign tmo_hit = (tcnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_ok) state_d = ST_SAMPLE;
      ST_SAMPLE:   if (scnt_q == SAMPLE_LAST) state_d = ST_COMPARE;
      ST_COMPARE:  state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (rdy_p)        state_d = ST_DECIDE;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_DECIDE:   state_d = (idx_q != '0) ? ST_COMPARE : ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; CLKC rises on entry to COMPARE
  always_comb begin
    cks_d   = cks_q;
    clkc_d  = clkc_q;
    busy_d  = busy_q;
    sar_d   = sar_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    comp_d  = comp_q;
`ifdef SAR_COMP_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_ok) begin
          cks_d  = 1'b1;
          busy_d = 1'b1;
          sar_d  = '0;
          scnt_d = '0;
        end
      end
      ST_SAMPLE: begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == SAMPLE_LAST) begin
          cks_d           = 1'b0;
          clkc_d          = 1'b1;
          sar_d           = '0;
          sar_d[NBIT-1]   = 1'b1;
          idx_d           = IDX_W'(NBIT - 1);
        end
      end
      ST_COMPARE: begin
        clkc_d = 1'b1;
`ifdef SAR_COMP_TIMEOUT_EN
        tcnt_d = '0;
`endif
      end
      ST_WAIT_RDY: begin
`ifdef SAR_COMP_TIMEOUT_EN
        tcnt_d = tcnt_q + 1'b1;
`endif
        if (rdy_p) begin
          comp_d = COMP_OUT;
          clkc_d = 1'b0;
        end else if (tmo_hit) begin
          clkc_d = 1'b0;
          err_d  = 1'b1;
          sar_d  = '0;
        end
      end
      ST_DECIDE: begin
        sar_d[idx_q] = comp_q;
        if (idx_q != '0) begin
          sar_d[idx_q - 1'b1] = 1'b1;
          idx_d               = idx_q - 1'b1;
          clkc_d              = 1'b1;
        end
      end
      ST_DONE: begin
        dout_d  = sar_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cks_q   <= 1'b0;
      clkc_q  <= 1'b0;
      busy_q  <= 1'b0;
      sar_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      scnt_q  <= '0;
      idx_q   <= '0;
      comp_q  <= 1'b0;
`ifdef SAR_COMP_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      cks_q   <= cks_d;
      clkc_q  <= clkc_d;
      busy_q  <= busy_d;
      sar_q   <= sar_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      comp_q  <= comp_d;
`ifdef SAR_COMP_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  assign CKS   = cks_q;
  assign CLKC  = clkc_q;
  assign DAC   = sar_q;
  assign BUSY  = busy_q;
  assign DOUT  = dout_q;
  assign VALID = valid_q;
  assign ERR   = err_q;

endmodule
